// File: rtl/exu_pkg.sv
// Shared definitions for the SwitchMCU R-type execution unit: widths,
// core phase numbers, the ALU operation enum and small helpers.
package exu_pkg;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

    // Core phase counter values used by the execution unit
    localparam logic [3:0] PH_RD = 4'd1;
    localparam logic [3:0] PH_OP = 4'd2;
    localparam logic [3:0] PH_EX = 4'd3;
    localparam logic [3:0] PH_WB = 4'd4;

    typedef enum logic [3:0] {
        OP_NONE,
        OP_ADD,
        OP_SUB,
        OP_SLL,
        OP_SLT,
        OP_SLTU,
        OP_XOR,
        OP_SRL,
        OP_SRA,
        OP_OR,
        OP_AND
    } alu_op_e;

    // Collapse the one-hot decoder strobes into a single op. Bit 0 is add,
    // bit 9 is and; lower bits win when the decoder asserts several.
    function automatic alu_op_e decodeOp(input logic [9:0] dec);
        alu_op_e op;
        if (dec[0])      op = OP_ADD;
        else if (dec[1]) op = OP_SUB;
        else if (dec[2]) op = OP_SLL;
        else if (dec[3]) op = OP_SLT;
        else if (dec[4]) op = OP_SLTU;
        else if (dec[5]) op = OP_XOR;
        else if (dec[6]) op = OP_SRL;
        else if (dec[7]) op = OP_SRA;
        else if (dec[8]) op = OP_OR;
        else if (dec[9]) op = OP_AND;
        else             op = OP_NONE;
        return op;
    endfunction

    // One step of a serial shift in the direction/kind selected by op
    function automatic logic [XLEN-1:0] shiftOne(input alu_op_e op, input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        case (op)
            OP_SLL:  r = {v[XLEN-2:0], 1'b0};
            OP_SRA:  r = {v[XLEN-1], v[XLEN-1:1]};
            default: r = {1'b0, v[XLEN-1:1]};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/exu_alu_swc.sv
// Purely combinational RV32I R-type ALU. Shifts use only b[4:0].
module exu_alu_swc
    import exu_pkg::*;
(
    input  alu_op_e          i_op,
    input  logic [XLEN-1:0]  i_a,
    input  logic [XLEN-1:0]  i_b,
    output logic [XLEN-1:0]  o_result
);

    logic [4:0] w_shamt;

    assign w_shamt = i_b[4:0];

    // Select the operation result; unknown/none yields zero
    always_comb begin
        o_result = '0;
        case (i_op)
            OP_ADD:  o_result = i_a + i_b;
            OP_SUB:  o_result = i_a - i_b;
            OP_SLL:  o_result = i_a << w_shamt;
            OP_SLT:  o_result = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            OP_SLTU: o_result = {{(XLEN-1){1'b0}}, (i_a < i_b)};
            OP_XOR:  o_result = i_a ^ i_b;
            OP_SRL:  o_result = i_a >> w_shamt;
            OP_SRA:  o_result = $unsigned($signed(i_a) >>> w_shamt);
            OP_OR:   o_result = i_a | i_b;
            OP_AND:  o_result = i_a & i_b;
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/exu_reg_swc.sv
// SwitchMCU register-register execution unit. Phase 1 reads rs1/rs2,
// phase 2 captures operands, phase 3 computes, phase 4 writes rd.
// Build option EXU_REG_SERIAL_SHIFT_EN replaces the barrel shift with a
// one-bit-per-clock shifter that stalls the core in phase 3.
module exu_reg_swc
    import exu_pkg::*;
#(
    parameter int XLEN = exu_pkg::XLEN,
    parameter int RA_W = exu_pkg::RA_W
) (
    input  logic             hclk,
    input  logic             hrstn,
    input  logic [3:0]       cycle_cnt,
    input  logic             en,
    input  logic             dec_add,
    input  logic             dec_sub,
    input  logic             dec_sll,
    input  logic             dec_slt,
    input  logic             dec_sltu,
    input  logic             dec_xor,
    input  logic             dec_srl,
    input  logic             dec_sra,
    input  logic             dec_or,
    input  logic             dec_and,
    input  logic [RA_W-1:0]  dec_rs1,
    input  logic [RA_W-1:0]  dec_rs2,
    input  logic [RA_W-1:0]  dec_rd,
    input  logic [XLEN-1:0]  pc,
    output logic [RA_W-1:0]  reg_raddr_1,
    output logic [RA_W-1:0]  reg_raddr_2,
    output logic             reg_ren_1,
    output logic             reg_ren_2,
    input  logic [XLEN-1:0]  reg_rdata_1,
    input  logic [XLEN-1:0]  reg_rdata_2,
    output logic [RA_W-1:0]  reg_waddr,
    output logic             reg_wen,
    output logic [XLEN-1:0]  reg_wdata,
    output logic             exu_stall
);

    logic [9:0]      w_dec;
    logic            w_act;
    alu_op_e         w_op;
    logic [XLEN-1:0] w_aluResult;
    logic            w_unused;

    logic [XLEN-1:0] r_opA;
    logic [XLEN-1:0] r_opB;
    logic [XLEN-1:0] r_result;

    assign w_dec    = {dec_and, dec_or, dec_sra, dec_srl, dec_xor,
                       dec_sltu, dec_slt, dec_sll, dec_sub, dec_add};
    assign w_act    = en & (|w_dec);
    assign w_op     = decodeOp(w_dec);
    assign w_unused = ^pc;

    exu_alu_swc u_alu (
        .i_op     (w_op),
        .i_a      (r_opA),
        .i_b      (r_opB),
        .o_result (w_aluResult)
    );

    // Regfile strobes: reads only in phase 1, write only in phase 4 to rd != x0
    always_comb begin
        reg_ren_1   = 1'b0;
        reg_ren_2   = 1'b0;
        reg_raddr_1 = '0;
        reg_raddr_2 = '0;
        reg_wen     = 1'b0;
        reg_waddr   = '0;
        reg_wdata   = '0;
        if (cycle_cnt == PH_RD) begin
            reg_ren_1   = w_act;
            reg_ren_2   = w_act;
            reg_raddr_1 = dec_rs1;
            reg_raddr_2 = dec_rs2;
        end else if (cycle_cnt == PH_WB) begin
            reg_wen   = w_act & (dec_rd != '0);
            reg_waddr = dec_rd;
            reg_wdata = r_result;
        end
    end

    // Capture regfile read data at the end of phase 2
    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            r_opA <= '0;
            r_opB <= '0;
        end else if (cycle_cnt == PH_OP && w_act) begin
            r_opA <= reg_rdata_1;
            r_opB <= reg_rdata_2;
        end
    end

`ifdef EXU_REG_SERIAL_SHIFT_EN
    logic            w_isShift;
    logic [4:0]      w_shAmt;
    logic            w_stall;
    logic            r_shBusy;
    logic [4:0]      r_shCnt;
    logic [XLEN-1:0] r_shVal;

    assign w_isShift = (w_op == OP_SLL) || (w_op == OP_SRL) || (w_op == OP_SRA);
    assign w_shAmt   = r_opB[4:0];
    assign w_stall   = (cycle_cnt == PH_EX) && w_act && w_isShift &&
                       (r_shBusy ? (r_shCnt != 5'd0) : (w_shAmt != 5'd0));
    assign exu_stall = w_stall;

    // Serial shifter: first phase-3 cycle does one step and loads the count,
    // each held cycle does one more step until the count is exhausted
    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            r_shBusy <= 1'b0;
            r_shCnt  <= '0;
            r_shVal  <= '0;
        end else if (cycle_cnt == PH_EX && w_act && w_isShift) begin
            if (!r_shBusy) begin
                if (w_shAmt != 5'd0) begin
                    r_shVal  <= shiftOne(w_op, r_opA);
                    r_shCnt  <= w_shAmt - 5'd1;
                    r_shBusy <= 1'b1;
                end
            end else if (r_shCnt != 5'd0) begin
                r_shVal <= shiftOne(w_op, r_shVal);
                r_shCnt <= r_shCnt - 5'd1;
            end else begin
                r_shBusy <= 1'b0;
            end
        end else if (cycle_cnt != PH_EX) begin
            r_shBusy <= 1'b0;
        end
    end

    // Latch the result on the last phase-3 cycle; serial shifts take theirs
    // from the shifter once it has drained
    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            r_result <= '0;
        end else if (cycle_cnt == PH_EX && w_act) begin
            if (!w_isShift || (!r_shBusy && w_shAmt == 5'd0)) begin
                r_result <= w_aluResult;
            end else if (r_shBusy && r_shCnt == 5'd0) begin
                r_result <= r_shVal;
            end
        end
    end
`else
    assign exu_stall = 1'b0;

    // Latch the ALU result at the end of phase 3
    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            r_result <= '0;
        end else if (cycle_cnt == PH_EX && w_act) begin
            r_result <= w_aluResult;
        end
    end
`endif

endmodule

// File: tb/tb_exu_reg_swc.sv
// Scoreboard bench for exu_reg_swc: a driver plays the core's phase counter
// and decoder, a regfile model answers reads, and a monitor compares every
// write strobe against the queue of expected writes.
module tb_exu_reg_swc;

    localparam logic [9:0] OP_ADD  = 10'b0000000001;
    localparam logic [9:0] OP_SUB  = 10'b0000000010;
    localparam logic [9:0] OP_SLL  = 10'b0000000100;
    localparam logic [9:0] OP_SLT  = 10'b0000001000;
    localparam logic [9:0] OP_SLTU = 10'b0000010000;
    localparam logic [9:0] OP_XOR  = 10'b0000100000;
    localparam logic [9:0] OP_SRL  = 10'b0001000000;
    localparam logic [9:0] OP_SRA  = 10'b0010000000;
    localparam logic [9:0] OP_OR   = 10'b0100000000;
    localparam logic [9:0] OP_AND  = 10'b1000000000;

`ifdef EXU_REG_SERIAL_SHIFT_EN
    localparam bit SERIAL = 1'b1;
`else
    localparam bit SERIAL = 1'b0;
`endif

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        hclk = 1'b0;
    logic        hrstn;
    logic [3:0]  cycle_cnt;
    logic        en;
    logic [9:0]  decOps;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] pc;
    logic [4:0]  reg_raddr_1, reg_raddr_2, reg_waddr;
    logic        reg_ren_1, reg_ren_2, reg_wen, exu_stall;
    logic [31:0] reg_rdata_1, reg_rdata_2, reg_wdata;

    logic [31:0] tbRegs [32];
    wr_t         expQ [$];
    wr_t         monExp;
    int          total = 0;
    int          bad = 0;

    exu_reg_swc dut (
        .hclk        (hclk),
        .hrstn       (hrstn),
        .cycle_cnt   (cycle_cnt),
        .en          (en),
        .dec_add     (decOps[0]),
        .dec_sub     (decOps[1]),
        .dec_sll     (decOps[2]),
        .dec_slt     (decOps[3]),
        .dec_sltu    (decOps[4]),
        .dec_xor     (decOps[5]),
        .dec_srl     (decOps[6]),
        .dec_sra     (decOps[7]),
        .dec_or      (decOps[8]),
        .dec_and     (decOps[9]),
        .dec_rs1     (rs1),
        .dec_rs2     (rs2),
        .dec_rd      (rd),
        .pc          (pc),
        .reg_raddr_1 (reg_raddr_1),
        .reg_raddr_2 (reg_raddr_2),
        .reg_ren_1   (reg_ren_1),
        .reg_ren_2   (reg_ren_2),
        .reg_rdata_1 (reg_rdata_1),
        .reg_rdata_2 (reg_rdata_2),
        .reg_waddr   (reg_waddr),
        .reg_wen     (reg_wen),
        .reg_wdata   (reg_wdata),
        .exu_stall   (exu_stall)
    );

    always #5 hclk = ~hclk;

    // Regfile model: read data appears the cycle after the read enable
    always @(posedge hclk) begin
        if (reg_ren_1) reg_rdata_1 <= tbRegs[reg_raddr_1];
        if (reg_ren_2) reg_rdata_2 <= tbRegs[reg_raddr_2];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write
    always @(negedge hclk) begin
        if (hrstn === 1'b1 && reg_wen === 1'b1) begin
            total++;
            if (expQ.size() == 0) begin
                bad++;
                $display("[TB] FAIL unexpected_write: got addr=%0d data=%h, expected no write", reg_waddr, reg_wdata);
            end else begin
                monExp = expQ.pop_front();
                if (reg_waddr !== monExp.addr || reg_wdata !== monExp.data) begin
                    bad++;
                    $display("[TB] FAIL write: got addr=%0d data=%h, expected addr=%0d data=%h",
                             reg_waddr, reg_wdata, monExp.addr, monExp.data);
                end
            end
        end
    end

    function automatic int expStallOf(input logic [9:0] ops, input logic [31:0] b);
        bit isShift;
        isShift = (ops == OP_SLL) || (ops == OP_SRL) || (ops == OP_SRA);
        return (SERIAL && isShift) ? int'(b[4:0]) : 0;
    endfunction

    // Drive one instruction through phases 1..4, holding phase 3 while stalled
    task automatic applyStimulus(input string name, input logic [9:0] ops, input logic enV,
                                 input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                                 input logic [31:0] a, input logic [31:0] b, input logic [31:0] expRes);
        logic act;
        logic expWr;
        int   stalls;
        act    = enV && (ops != 10'd0);
        expWr  = act && (d != 5'd0);
        tbRegs[s1] = a;
        tbRegs[s2] = b;
        if (expWr) expQ.push_back('{d, expRes});
        @(posedge hclk); #1;
        en = enV; decOps = ops; rs1 = s1; rs2 = s2; rd = d; cycle_cnt = 4'd1;
        @(negedge hclk);
        checkOutput({name, "_ren1"}, {31'd0, reg_ren_1}, {31'd0, act});
        checkOutput({name, "_ren2"}, {31'd0, reg_ren_2}, {31'd0, act});
        if (act) begin
            checkOutput({name, "_raddr1"}, {27'd0, reg_raddr_1}, {27'd0, s1});
            checkOutput({name, "_raddr2"}, {27'd0, reg_raddr_2}, {27'd0, s2});
        end
        @(posedge hclk); #1;
        cycle_cnt = 4'd2;
        @(negedge hclk);
        checkOutput({name, "_wen_ph2"}, {31'd0, reg_wen}, 32'd0);
        @(posedge hclk); #1;
        cycle_cnt = 4'd3;
        stalls = 0;
        forever begin
            @(negedge hclk);
            if (exu_stall !== 1'b1 || stalls > 40) break;
            stalls++;
            @(posedge hclk); #1;
        end
        checkOutput({name, "_stall_cycles"}, stalls, act ? expStallOf(ops, b) : 0);
        @(posedge hclk); #1;
        cycle_cnt = 4'd4;
        @(negedge hclk);
        checkOutput({name, "_wen_ph4"}, {31'd0, reg_wen}, {31'd0, expWr});
        @(posedge hclk); #1;
        cycle_cnt = 4'd0; en = 1'b0; decOps = 10'd0;
    endtask

    // Start an add, then pull reset during phase 3; nothing may be written
    task automatic applyResetAbort();
        tbRegs[2] = 32'd7;
        tbRegs[4] = 32'd9;
        @(posedge hclk); #1;
        en = 1'b1; decOps = OP_ADD; rs1 = 5'd2; rs2 = 5'd4; rd = 5'd20; cycle_cnt = 4'd1;
        @(posedge hclk); #1;
        cycle_cnt = 4'd2;
        @(posedge hclk); #1;
        cycle_cnt = 4'd3;
        #2;
        hrstn = 1'b0;
        cycle_cnt = 4'd0;
        @(negedge hclk);
        checkOutput("rst_abort_wen", {31'd0, reg_wen}, 32'd0);
        checkOutput("rst_abort_stall", {31'd0, exu_stall}, 32'd0);
        @(posedge hclk); #1;
        hrstn = 1'b1;
        @(negedge hclk);
        checkOutput("rst_after_ren1", {31'd0, reg_ren_1}, 32'd0);
        checkOutput("rst_after_wen", {31'd0, reg_wen}, 32'd0);
        checkOutput("rst_after_wdata", reg_wdata, 32'd0);
        checkOutput("rst_after_waddr", {27'd0, reg_waddr}, 32'd0);
        checkOutput("rst_after_raddr1", {27'd0, reg_raddr_1}, 32'd0);
        @(posedge hclk); #1;
        en = 1'b0; decOps = 10'd0;
        // Phase 4 with the aborted instruction's decode must show a cleared result
        en = 1'b1; decOps = OP_ADD; rd = 5'd20; cycle_cnt = 4'd4;
        expQ.push_back('{5'd20, 32'd0});
        @(posedge hclk); #1;
        cycle_cnt = 4'd0; en = 1'b0; decOps = 10'd0;
    endtask

    // Watchdog so a stuck handshake can never hang the run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        for (int i = 0; i < 32; i++) tbRegs[i] = 32'd0;
        hrstn = 1'b0; cycle_cnt = 4'd0; en = 1'b0; decOps = 10'd0;
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; pc = 32'h0000_1000;
        repeat (2) @(posedge hclk);
        @(negedge hclk);
        checkOutput("reset_ren1", {31'd0, reg_ren_1}, 32'd0);
        checkOutput("reset_wen", {31'd0, reg_wen}, 32'd0);
        checkOutput("reset_wdata", reg_wdata, 32'd0);
        checkOutput("reset_stall", {31'd0, exu_stall}, 32'd0);
        @(posedge hclk); #1;
        hrstn = 1'b1;

        applyStimulus("add",      OP_ADD,  1'b1, 5'd2, 5'd4, 5'd5,  32'd5,         32'd3,      32'd8);
        applyStimulus("sub",      OP_SUB,  1'b1, 5'd2, 5'd4, 5'd5,  32'd5,         32'd3,      32'd2);
        applyStimulus("sub_neg",  OP_SUB,  1'b1, 5'd2, 5'd4, 5'd5,  32'd3,         32'd5,      32'hFFFF_FFFE);
        applyStimulus("sra",      OP_SRA,  1'b1, 5'd6, 5'd7, 5'd6,  32'h8000_0000, 32'd4,      32'hF800_0000);
        applyStimulus("srl",      OP_SRL,  1'b1, 5'd6, 5'd7, 5'd7,  32'h8000_0000, 32'd4,      32'h0800_0000);
        applyStimulus("sll_b33",  OP_SLL,  1'b1, 5'd8, 5'd9, 5'd8,  32'd1,         32'd33,     32'h0000_0002);
        applyStimulus("slt",      OP_SLT,  1'b1, 5'd1, 5'd3, 5'd9,  32'hFFFF_FFFF, 32'd1,      32'd1);
        applyStimulus("sltu",     OP_SLTU, 1'b1, 5'd1, 5'd3, 5'd10, 32'hFFFF_FFFF, 32'd1,      32'd0);
        applyStimulus("xor",      OP_XOR,  1'b1, 5'd11, 5'd12, 5'd11, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0);
        applyStimulus("or",       OP_OR,   1'b1, 5'd11, 5'd12, 5'd12, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0);
        applyStimulus("and",      OP_AND,  1'b1, 5'd11, 5'd12, 5'd13, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
        applyStimulus("sll3",     OP_SLL,  1'b1, 5'd14, 5'd15, 5'd14, 32'd5,        32'd3,      32'h0000_0028);
        applyStimulus("sra_amt0", OP_SRA,  1'b1, 5'd16, 5'd17, 5'd16, 32'h8000_0000, 32'd32,    32'h8000_0000);
        applyStimulus("prio",     OP_ADD | OP_SUB, 1'b1, 5'd2, 5'd4, 5'd15, 32'd5, 32'd3,       32'd8);
        applyStimulus("rd_zero",  OP_ADD,  1'b1, 5'd2, 5'd4, 5'd0,  32'd5,         32'd3,      32'd8);
        applyStimulus("en_low",   OP_ADD,  1'b0, 5'd2, 5'd4, 5'd5,  32'd5,         32'd3,      32'd8);
        applyStimulus("no_op",    10'd0,   1'b1, 5'd2, 5'd4, 5'd5,  32'd5,         32'd3,      32'd8);

        applyResetAbort();

        repeat (3) @(posedge hclk);
        @(negedge hclk);
        checkOutput("pending_writes", expQ.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exu_reg_swc.md
Name: exu_reg_swc

Overview:
- Register-register (R-type) ALU execution unit of the SwitchMCU multi-cycle core.
- Sequenced by the core-wide phase counter cycle_cnt (0 after reset, then 1,2,3,4,1,…).
- Reads two operands from the register file, computes one of ten RV32I R-type operations, and writes the result back to rd in phase 4.

Parameters:
- XLEN, 32, datapath width (only 32 supported).
- RA_W, 5, register address width.

Ports:
- hclk  in  1  clock, rising edge.
- hrstn  in  1  reset, asynchronous, active-low.
- cycle_cnt  in  4  core phase counter (0 = idle after reset, 1..4 = instruction phases).
- en  in  1  this unit owns the current instruction.
- dec_add, dec_sub, dec_sll, dec_slt, dec_sltu, dec_xor, dec_srl, dec_sra, dec_or, dec_and  in  1 each  one-hot op select.
- dec_rs1, dec_rs2, dec_rd  in  5 each  source/destination register indices.
- pc  in  32  current PC; reserved, no effect on behaviour.
- reg_raddr_1, reg_raddr_2  out  5 each  regfile read addresses.
- reg_ren_1, reg_ren_2  out  1 each  regfile read enables.
- reg_rdata_1, reg_rdata_2  in  32 each  regfile read data, valid the phase after ren.
- reg_waddr  out  5  regfile write address.
- reg_wen  out  1  regfile write enable.
- reg_wdata  out  32  regfile write data.
- exu_stall  out  1  request for the core to hold cycle_cnt.

Behaviour:
- act = en & (OR of all dec_* ops). With act=0, no read/write strobes are asserted and internal registers hold.
- Multiple ops asserted: priority add>sub>sll>slt>sltu>xor>srl>sra>or>and.
- Phase 1: reg_ren_1 = reg_ren_2 = act; reg_raddr_1 = dec_rs1, reg_raddr_2 = dec_rs2 (combinational). Outside phase 1, ren = 0 and raddr = 0.
- Phase 2: at the rising edge ending phase 2, if act, latch op_a <= reg_rdata_1 and op_b <= reg_rdata_2.
- Phase 3: at the rising edge ending phase 3, if act, latch result <= ALU(op_a, op_b).
- ALU: add a+b mod 2^32; sub a−b mod 2^32; sll a<<b[4:0]; srl logical a>>b[4:0]; sra arithmetic a>>>b[4:0]; xor/or/and bitwise; slt = signed(a)<signed(b) ? 1 : 0; sltu = unsigned compare ? 1 : 0. Only b[4:0] is used for shifts.
- Phase 4: reg_wen = act & (dec_rd != 0); reg_waddr = dec_rd; reg_wdata = result. Outside phase 4, wen = 0, waddr = 0, wdata = 0. rd = x0 is never written.
- Phase 0, or cycle_cnt > 4: all strobes 0, no register updates.
- dec_* / en are sampled in each phase and must be held stable by the decoder for phases 1–4.
- Reset (async, hrstn=0): op_a, op_b, result, and shift state cleared to 0. All outputs 0 because phase 0 follows reset.
- Reset mid-instruction aborts it; no write occurs.
- exu_stall = 0 constantly (base build).

Optional Feature:
- Macro EXU_REG_SERIAL_SHIFT_EN.
- Defined: sll/srl/sra are computed serially, one bit per clock, in phase 3. exu_stall = 1 from the first phase-3 cycle until the remaining shift count reaches 0. The core holds cycle_cnt at 3 while exu_stall = 1; result is latched on the final cycle.
- Shift amount 0: no stall.
- Non-shift ops: never stall.
- Not defined: single-cycle barrel shifter, exu_stall tied 0.
- Results are identical in both builds.

Decomposition:
- Shared package exu_pkg: XLEN, RA_W, phase constants PH_RD=1, PH_OP=2, PH_EX=3, PH_WB=4, and the ALU op enum (derived from one-hot dec_*).
- One sub-module is natural: exu_alu_swc, purely combinational (op, a, b → result). The serial shifter lives in the parent.

Test Plan:
- add, rs1=2 (data 5), rs2=4 (data 3), rd=5 → phase 1 ren_1 = ren_2 = 1, raddr 2/4; phase 4 wen = 1, waddr = 5, wdata = 8.
- Same operands, switch to sub → wdata = 2. Operands a=3, b=5 → wdata = 0xFFFFFFFE.
- sra a=0x80000000, b=4 → 0xF8000000. srl same operands → 0x08000000. sll a=1, b=33 → 0x00000002 (b[4:0]=1).
- slt a=0xFFFFFFFF, b=1 → 1. sltu same operands → 0. xor/or/and with a=0xF0F0, b=0xFF00 → 0x0FF0 / 0xFFF0 / 0xF000.
- rd=0, or en=0, or no dec_* asserted → reg_wen stays 0 throughout. With en=0, ren stays 0 as well.
- hrstn pulled low in phase 3 → no write. After release, cycle_cnt=0 and all outputs 0. With EXU_REG_SERIAL_SHIFT_EN, sll by 3 → exu_stall high 3 cycles, correct result.
